// File: rtl/conv_enc_k3.sv
// Rate 1/2, K=3 convolutional encoder (generators 111 / 101) with valid/ready
// handshakes, optional two-bit zero flush per frame and a running pair counter.
module conv_enc_k3 #(
  parameter bit          TAIL_EN = 1'b1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       tx_pair,
  output logic             out_last,
  output logic [CNT_W-1:0] pair_cnt,
  output logic             frame_done
);

  typedef enum logic [1:0] {DATA, TAIL1, TAIL2} state_t;

  state_t     state, state_nxt;
  logic [1:0] sr, sr_nxt;
  logic [1:0] pair_nxt;
  logic       valid_nxt, last_nxt;
  logic       can_load, accept, handoff;

  // Coded pair for input d given shift register s: {111, 101}
  function automatic logic [1:0] encode(input logic d, input logic [1:0] s);
    return {d ^ s[1] ^ s[0], d ^ s[0]};
  endfunction

  assign can_load = !out_valid || out_ready;
  assign in_ready = (state == DATA) && can_load;
  assign accept   = in_valid && in_ready;
  assign handoff  = out_valid && out_ready;

  // Next-state, shift register and output-register load decisions
  always_comb begin
    state_nxt = state;
    sr_nxt    = sr;
    pair_nxt  = tx_pair;
    last_nxt  = out_last;
    valid_nxt = out_valid && !out_ready;
    case (state)
      DATA: begin
        if (accept) begin
          pair_nxt  = encode(in_bit, sr);
          valid_nxt = 1'b1;
          sr_nxt    = {in_bit, sr[1]};
          last_nxt  = 1'b0;
          if (in_last) begin
            if (TAIL_EN) begin
              state_nxt = TAIL1;
            end else begin
              last_nxt = 1'b1;
              sr_nxt   = 2'b00;
            end
          end
        end
      end
      TAIL1: begin
        if (can_load) begin
          pair_nxt  = encode(1'b0, sr);
          valid_nxt = 1'b1;
          last_nxt  = 1'b0;
          sr_nxt    = {1'b0, sr[1]};
          state_nxt = TAIL2;
        end
      end
      TAIL2: begin
        if (can_load) begin
          pair_nxt  = encode(1'b0, sr);
          valid_nxt = 1'b1;
          last_nxt  = 1'b1;
          sr_nxt    = 2'b00;
          state_nxt = DATA;
        end
      end
      default: begin
        state_nxt = DATA;
        sr_nxt    = 2'b00;
      end
    endcase
  end

  // State, shift register and single-entry output register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= DATA;
      sr        <= 2'b00;
      out_valid <= 1'b0;
      tx_pair   <= 2'b00;
      out_last  <= 1'b0;
    end else begin
      state     <= state_nxt;
      sr        <= sr_nxt;
      out_valid <= valid_nxt;
      tx_pair   <= pair_nxt;
      out_last  <= last_nxt;
    end
  end

  // Handoff counter (wrapping) and end-of-frame pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pair_cnt   <= '0;
      frame_done <= 1'b0;
    end else begin
      if (handoff) pair_cnt <= pair_cnt + CNT_W'(1);
      frame_done <= handoff && out_last;
    end
  end

endmodule
